deemphasis_mc: RTL and testbench
================================

Name: deemphasis_mc

Overview:
Multi-channel, mode-switchable FM de-emphasis filter; successor to the single-channel 16-bit deemphasis block. Implements first-order IIR y[n] = y[n-1] + k*(x[n] - y[n-1]) per channel, with k selected at run time for 50 us, 75 us or bypass. Sits after the stereo decoder at the audio sample rate (32 kHz) and accepts one packed multi-channel sample frame per valid strobe. One shared multiplier is time-multiplexed across channels.

Parameters:
WIDTH, 16, sample width per channel, signed two's complement
CHANNELS, 2, number of channels, 1..8
COEF_W, 16, coefficient width; k is unsigned fraction k/2^COEF_W
FRAC, 8, fractional guard bits held in each channel state register
K50, 30457, coefficient for tau = 50 us at 32 kHz (1 - exp(-T/tau))
K75, 22332, coefficient for tau = 75 us at 32 kHz

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
mode  input  2  00 = 50 us, 01 = 75 us, 1x = bypass; sampled on frame accept
in_valid  input  1  input frame present
in_ready  output  1  block can accept a frame (FSM in IDLE)
in  input  CHANNELS*WIDTH  packed samples, channel 0 in LSBs
out_valid  output  1  one-cycle pulse; out updated this cycle
out  output  CHANNELS*WIDTH  packed filtered samples, channel 0 in LSBs

Behaviour:
- Reset: FSM = IDLE; all channel states = 0; out = 0; out_valid = 0; in_ready = 1. Reset mid-frame aborts; no out_valid for the aborted frame.
- FSM: IDLE -> CALC on in_valid && in_ready (latch in and mode, ch = 0). CALC: one channel per cycle; ch increments; after ch = CHANNELS-1 -> DONE. DONE: load out from all states, out_valid = 1 for this cycle only -> IDLE.
- in_ready = 1 only in IDLE. in_valid while not ready is ignored (frame dropped, no stall of internal state). in changing during CALC has no effect.
- Latency: accept edge E; out and out_valid change at edge E+CHANNELS+1. Throughput: one frame per CHANNELS+2 cycles. Back-to-back in_valid held high gives an accept at every IDLE.
- Arithmetic per channel: state s is signed WIDTH+FRAC bits (x scaled by 2^FRAC). e = (x <<< FRAC) - s, WIDTH+FRAC+1 bits, exact. p = e * k, signed, full width. s_new = s + (p >>> COEF_W) (arithmetic shift, floor). Clamp s_new to [-2^(WIDTH-1) * 2^FRAC, (2^(WIDTH-1)-1) * 2^FRAC]; no wrap-around permitted.
- Output per channel: out = s >>> FRAC (floor, no rounding).
- Bypass: s_new = x <<< FRAC, so out = in exactly. Leaving bypass continues filtering from the last input, with no step.
- Mode change takes effect on the next accepted frame only. Never mid-frame.
- out holds its value between out_valid pulses.
- CHANNELS = 1 is legal: CALC lasts one cycle.

Test Plan:
- Reset then idle: out = 0, out_valid = 0, in_ready = 1. Assert reset during CALC: no out_valid, states cleared, next frame of zeros gives out = 0.
- Impulse, mode 00, CHANNELS = 2: ch0 = 32767 for one frame, then zeros. out ch0 = 15228, then 8151 ±1, decaying monotonically to 0 within 30 frames. ch1 = 0 throughout. Repeat with -32767: first output -15229.
- Step, mode 01: ch0 = 32767 held. First output 11 ±1 of 32767*22332/65536, i.e. 11166 ±1. Monotonic rise, no overshoot, never > 32767, reaches ≥ 32765 within 40 frames. Then -32768 held: settles at -32768, no wrap to positive.
- Bypass: mode 10, random frames: out equals in frame-for-frame. Switch to mode 00 with the same input held: out unchanged, no step.
- Handshake: pulse in_valid during CALC: ignored, in_ready = 0. out_valid exactly CHANNELS+1 cycles after accept, width 1 cycle. in_valid held high: frames accepted every CHANNELS+2 cycles.
- Channel independence, CHANNELS = 4: distinct steps per channel (+1000, -1000, 32767, 0), mode 00. Each channel matches a scalar reference model bit-exactly. Mode toggled mid-frame affects only the next frame.

Source files
------------

// File: rtl/deemphasis_mc.sv
// Multi-channel first-order IIR FM de-emphasis: y += k*(x - y) per channel, one shared
// multiplier stepped across the channels one per clock, selectable 50 us / 75 us / bypass.
module deemphasis_mc #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int COEF_W   = 16,
  parameter int FRAC     = 8,
  parameter int K50      = 30457,
  parameter int K75      = 22332
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out
);
  localparam int SW   = WIDTH + FRAC;      // channel state width
  localparam int EW   = SW + 1;            // exact error width
  localparam int PW   = EW + COEF_W + 1;   // full product width
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CH_W-1:0]      CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic signed [PW-1:0] ONE     = PW'(1);
  localparam logic signed [PW-1:0] S_MAX   = (ONE <<< (SW - 1)) - (ONE <<< FRAC);
  localparam logic signed [PW-1:0] S_MIN   = -(ONE <<< (SW - 1));
  localparam logic [COEF_W-1:0]    K50_C   = COEF_W'(K50);
  localparam logic [COEF_W-1:0]    K75_C   = COEF_W'(K75);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CH_W-1:0]           ch;
  logic [CHANNELS*WIDTH-1:0] in_lat;
  logic [1:0]                mode_lat;
  logic signed [SW-1:0]      st [CHANNELS];

  logic signed [WIDTH-1:0]   x;
  logic signed [SW-1:0]      s_cur, s_new;
  logic [COEF_W-1:0]         k;
  logic signed [EW-1:0]      e;
  logic signed [PW-1:0]      e_x, k_x, p, acc;

  // Shared datapath for the channel selected by ch.
  always_comb begin
    x     = in_lat[ch*WIDTH +: WIDTH];
    s_cur = st[ch];
    k     = mode_lat[0] ? K75_C : K50_C;
    e     = $signed({x[WIDTH-1], x, {FRAC{1'b0}}}) - $signed({s_cur[SW-1], s_cur});
    e_x   = PW'(e);
    k_x   = PW'($signed({1'b0, k}));
    p     = e_x * k_x;
    acc   = PW'(s_cur) + (p >>> COEF_W);
    s_new = acc[SW-1:0];
    if (mode_lat[1])      s_new = {x, {FRAC{1'b0}}};
    else if (acc > S_MAX) s_new = S_MAX[SW-1:0];
    else if (acc < S_MIN) s_new = S_MIN[SW-1:0];
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (ch == CH_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ch        <= '0;
      in_lat    <= '0;
      mode_lat  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state == DONE);
      if (state == IDLE && in_valid) begin
        in_lat   <= in;
        mode_lat <= mode;
        ch       <= '0;
      end
      if (state == CALC) ch <= ch + CH_W'(1);
      if (state == DONE) begin
        for (int i = 0; i < CHANNELS; i++) out[i*WIDTH +: WIDTH] <= st[i][SW-1:FRAC];
      end
    end
  end

  // NOTE: the channel state array is reset on purpose: a restarted filter must begin from
  // silence, so this storage stays in resettable flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) st[i] <= '0;
    end else if (state == CALC) begin
      st[ch] <= s_new;
    end
  end
endmodule

// File: tb/tb_deemphasis_mc.sv
// Scoreboard bench for deemphasis_mc: a 2-channel and a 4-channel instance, checked against
// an integer-arithmetic model of the filter equations with floor division and clamping.
module tb_deemphasis_mc;
  typedef struct {
    logic [63:0] data;
    longint      edge_no;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode_a [2];
  logic        vld    [2];
  logic [63:0] din    [2];
  logic        rdy2, rdy4, ov2, ov4;
  logic [31:0] dout2;
  logic [63:0] dout4;

  int          tests = 0;
  int          fails = 0;
  longint      cyc   = 0;
  longint      ms       [2][4];
  int          busy     [2];
  int          acc_cnt  [2];
  logic        prev_ov  [2];
  logic [63:0] last_out [2];
  exp_t        sb0 [$];
  exp_t        sb1 [$];
  int          h2 [$];
  longint      ov_edges [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  deemphasis_mc #(.CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset), .mode(mode_a[0]), .in_valid(vld[0]), .in_ready(rdy2),
    .in(din[0][31:0]), .out_valid(ov2), .out(dout2));

  deemphasis_mc #(.CHANNELS(4)) dut4 (
    .clk(clk), .reset(reset), .mode(mode_a[1]), .in_valid(vld[1]), .in_ready(rdy4),
    .in(din[1]), .out_valid(ov4), .out(dout4));

  function automatic int nch(input int w);
    return (w == 0) ? 2 : 4;
  endfunction

  function automatic longint lane(input logic [63:0] f, input int c);
    logic signed [15:0] v;
    v = f[16*c +: 16];
    return longint'(v);
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Reference filter: state is the sample scaled by 256, k is a fraction of 65536.
  function automatic longint ref_step(input longint s, input longint x, input logic [1:0] md);
    longint lo, hi, k, ns;
    lo = -32768 * 256;
    hi = 32767 * 256;
    if (md[1]) return x * 256;
    k  = (md == 2'b00) ? 30457 : 22332;
    ns = s + fdiv((x * 256 - s) * k, 65536);
    if (ns > hi) ns = hi;
    if (ns < lo) ns = lo;
    return ns;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo,
                             input longint hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: expected frames enter the scoreboard at acceptance, leave at out_valid.
  task automatic mon(input int w, input logic v, input logic rdy, input logic ov,
                     input logic [63:0] d_in, input logic [63:0] d_out, input logic [1:0] md);
    exp_t e;
    logic exp_rdy;
    int   n;
    n = nch(w);
    if (reset) begin
      busy[w]     = 0;
      prev_ov[w]  = 1'b0;
      last_out[w] = '0;
      for (int c = 0; c < 4; c++) ms[w][c] = 0;
      if (w == 0) sb0.delete(); else sb1.delete();
      return;
    end
    exp_rdy = (busy[w] == 0);
    if (v) check($sformatf("in_ready dut%0d", w), rdy, exp_rdy);
    if (v && exp_rdy) begin
      e.data    = '0;
      e.edge_no = cyc + 1;
      for (int c = 0; c < n; c++) begin
        ms[w][c] = ref_step(ms[w][c], lane(d_in, c), md);
        e.data[16*c +: 16] = 16'(fdiv(ms[w][c], 256));
      end
      if (w == 0) sb0.push_back(e); else sb1.push_back(e);
      acc_cnt[w]++;
      busy[w] = n + 1;
    end else if (busy[w] > 0) begin
      busy[w]--;
    end
    if (ov) begin
      check($sformatf("out_valid width dut%0d", w), prev_ov[w], 0);
      check($sformatf("scoreboard has frame dut%0d", w),
            (w == 0) ? sb0.size() > 0 : sb1.size() > 0, 1);
      if ((w == 0) ? sb0.size() > 0 : sb1.size() > 0) begin
        if (w == 0) e = sb0.pop_front(); else e = sb1.pop_front();
        for (int c = 0; c < n; c++)
          check($sformatf("out dut%0d ch%0d", w, c), lane(d_out, c), lane(e.data, c));
        check($sformatf("latency dut%0d", w), cyc - e.edge_no, n + 1);
      end
      last_out[w] = d_out;
      if (w == 0) h2.push_back(int'(lane(d_out, 0)));
      else        ov_edges.push_back(cyc);
    end else begin
      check($sformatf("out hold dut%0d", w), d_out, last_out[w]);
    end
    prev_ov[w] = ov;
  endtask

  always @(negedge clk) begin
    mon(0, vld[0], rdy2, ov2, {32'b0, din[0][31:0]}, {32'b0, dout2}, mode_a[0]);
    mon(1, vld[1], rdy4, ov4, din[1], dout4, mode_a[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int w, input int cnt);
    int start, n;
    start = acc_cnt[w];
    n     = 0;
    while (acc_cnt[w] - start < cnt && n < 400) begin
      tick();
      n++;
    end
    check($sformatf("accepted frames dut%0d", w), acc_cnt[w] - start, cnt);
  endtask

  // Offer a frame with in_valid held for 'frames' accepts, then scramble in/mode; 'poke'
  // pulses in_valid once while the block is busy.
  task automatic send(input int w, input logic [63:0] f, input logic [1:0] md,
                      input int frames, input bit poke);
    din[w]    = f;
    mode_a[w] = md;
    vld[w]    = 1'b1;
    wait_accepts(w, frames);
    vld[w]    = 1'b0;
    din[w]    = {$urandom, $urandom};
    mode_a[w] = 2'($urandom);
    if (poke) begin
      tick();
      vld[w] = 1'b1;
      tick();
      vld[w] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while ((busy[w] != 0 || ((w == 0) ? sb0.size() : sb1.size()) != 0) && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("drain dut%0d", w), n < 100, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f;
    int          viol, prev;
    for (int w = 0; w < 2; w++) begin
      vld[w] = 1'b0; din[w] = '0; mode_a[w] = 2'b00;
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset out2", dout2, 0);
    check("reset out4", dout4, 0);
    check("reset out_valid2", ov2, 0);
    check("reset out_valid4", ov4, 0);
    check("reset in_ready2", rdy2, 1);
    check("reset in_ready4", rdy4, 1);
    tick();

    // Build up state, abort a frame with reset, then zeros must read back as zero.
    send(0, pack4(20000, -20000, 0, 0), 2'b00, 1, 0);
    wait_idle(0);
    send(0, pack4(12345, -22222, 0, 0), 2'b00, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("abort out cleared", dout2, 0);
    send(0, pack4(0, 0, 0, 0), 2'b00, 1, 0);
    wait_idle(0);
    check("zeros after abort", dout2, 0);

    // Impulse, 50 us.
    send(0, pack4(32767, 0, 0, 0), 2'b00, 1, 0);
    wait_idle(0);
    check("impulse first", lane({32'b0, dout2}, 0), 15228);
    check("impulse ch1", lane({32'b0, dout2}, 1), 0);
    send(0, pack4(0, 0, 0, 0), 2'b00, 1, 0);
    wait_idle(0);
    check_range("impulse second", lane({32'b0, dout2}, 0), 8150, 8152);
    viol = 0;
    prev = int'(lane({32'b0, dout2}, 0));
    for (int i = 0; i < 28; i++) begin
      send(0, pack4(0, 0, 0, 0), 2'b00, 1, 0);
      wait_idle(0);
      if (lane({32'b0, dout2}, 0) > prev || lane({32'b0, dout2}, 1) != 0) viol++;
      prev = int'(lane({32'b0, dout2}, 0));
    end
    check("impulse monotonic decay", viol, 0);
    check("impulse settled", lane({32'b0, dout2}, 0), 0);
    send(0, pack4(-32767, 0, 0, 0), 2'b00, 1, 0);
    wait_idle(0);
    check("neg impulse first", lane({32'b0, dout2}, 0), -15229);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // Step up then full-scale negative step, 75 us, in_valid held.
    h2.delete();
    send(0, pack4(32767, 0, 0, 0), 2'b01, 40, 0);
    wait_idle(0);
    check("step frames", h2.size(), 40);
    check_range("step first", h2[0], 11165, 11167);
    viol = 0;
    for (int i = 0; i < h2.size(); i++)
      if (h2[i] > 32767 || (i > 0 && h2[i] < h2[i-1])) viol++;
    check("step monotonic", viol, 0);
    check_range("step final", h2[h2.size()-1], 32765, 32767);
    h2.delete();
    send(0, pack4(-32768, 0, 0, 0), 2'b01, 40, 0);
    wait_idle(0);
    viol = 0;
    for (int i = 1; i < h2.size(); i++) if (h2[i] > h2[i-1]) viol++;
    check("neg step monotonic", viol, 0);
    check("neg step final", h2[h2.size()-1], -32768);

    // Bypass passes frames through; switching to 50 us with the same input holds the output.
    for (int i = 0; i < 8; i++) begin
      f = {32'b0, 32'($urandom)};
      send(0, f, {1'b1, 1'($urandom)}, 1, 0);
      wait_idle(0);
      check("bypass", dout2, f[31:0]);
    end
    send(0, f, 2'b00, 3, 0);
    wait_idle(0);
    check("bypass to 50us no step", dout2, f[31:0]);

    // Handshake on the 4-channel instance.
    send(1, pack4(100, 200, 300, 400), 2'b00, 1, 1);
    wait_idle(1);
    send(1, pack4(-5, 6, -7, 8), 2'b01, 1, 0);
    @(negedge clk);
    check("in_ready low in CALC", rdy4, 0);
    tick();
    wait_idle(1);
    ov_edges.delete();
    send(1, pack4(1, 2, 3, 4), 2'b00, 6, 0);
    wait_idle(1);
    check("stream outputs", ov_edges.size(), 6);
    for (int i = 1; i < ov_edges.size(); i++)
      check("stream spacing", ov_edges[i] - ov_edges[i-1], 6);

    // Distinct per-channel steps, 50 us.
    send(1, pack4(1000, -1000, 32767, 0), 2'b00, 12, 0);
    wait_idle(1);
    check("ch3 stays zero", lane(dout4, 3), 0);

    // Random frames, modes, hold lengths and busy-time pokes on both instances.
    for (int i = 0; i < 25; i++) begin
      send(0, {32'b0, 32'($urandom)}, 2'($urandom), 1 + int'($urandom_range(2)),
           1'($urandom));
      send(1, {$urandom, $urandom}, 2'($urandom), 1 + int'($urandom_range(2)),
           1'($urandom));
    end
    wait_idle(0);
    wait_idle(1);
    check("scoreboard empty dut0", sb0.size(), 0);
    check("scoreboard empty dut1", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
